// File: rtl/local_history_table_if.sv
// ---------------------------------------------------------------------------
// local_history_table_if
//   Request/response bundle between the branch unit and the local history
//   table.
//
//   master (branch unit)   : drives lookup_* / update_*, reads ready and the
//                            history response
//   slave  (history table) : the reverse
//
//   lookup_valid / lookup_pc                    lookup request
//   update_valid / update_pc / update_taken     resolved branch outcome
//   ready                                       table swept and accepting
//   history_valid / history_out                 registered lookup result
// ---------------------------------------------------------------------------
interface local_history_table_if #(
    parameter int PC_W   = 32,
    parameter int HIST_W = 10
);
    logic              lookup_valid;
    logic [PC_W-1:0]   lookup_pc;
    logic              update_valid;
    logic [PC_W-1:0]   update_pc;
    logic              update_taken;
    logic              ready;
    logic              history_valid;
    logic [HIST_W-1:0] history_out;

    modport master (
        output lookup_valid, lookup_pc, update_valid, update_pc, update_taken,
        input  ready, history_valid, history_out
    );

    modport slave (
        input  lookup_valid, lookup_pc, update_valid, update_pc, update_taken,
        output ready, history_valid, history_out
    );
endinterface

// File: rtl/local_history_table.sv
// ---------------------------------------------------------------------------
// local_history_table
//   Per-branch local taken/not-taken shift history, indexed by pc[IDX_W+1:2].
//   Upper PC bits are ignored, so aliasing branches share one entry.
//   After reset a sweep clears one entry per cycle; ready rises once the
//   last entry has been cleared. Lookups return the entry one cycle later;
//   a same-cycle update of the looked-up entry is bypassed into the result.
//
//   Ports
//     clock   : sole clock, rising edge
//     reset   : synchronous, active-high; restarts the clear sweep
//     lht_if  : slave side of local_history_table_if (lookup, update,
//               ready, history response)
// ---------------------------------------------------------------------------
module local_history_table #(
    parameter int ENTRIES = 64,
    parameter int HIST_W  = 10,
    parameter int PC_W    = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    local_history_table_if.slave  lht_if
);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              hist_valid_q, hist_valid_d;
    logic [HIST_W-1:0] hist_out_q, hist_out_d;

    // NOTE: the history array has no reset; the post-reset sweep clears it,
    // which keeps it mappable onto plain RAM without a reset port.
    logic [HIST_W-1:0] table_q [ENTRIES];

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [HIST_W-1:0] wr_data;

    logic [IDX_W-1:0]  lookup_idx;
    logic [IDX_W-1:0]  update_idx;
    logic [HIST_W-1:0] update_hist;

    assign lookup_idx  = lht_if.lookup_pc[IDX_W+1:2];
    assign update_idx  = lht_if.update_pc[IDX_W+1:2];
    // Oldest outcome falls off the MSB; newest enters at the LSB.
    assign update_hist = {table_q[update_idx][HIST_W-2:0], lht_if.update_taken};

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        hist_valid_d = 1'b0;
        hist_out_d   = hist_out_q;
        wr_en        = 1'b0;
        wr_idx       = ptr_q;
        wr_data      = '0;

        unique case (state_q)
            ST_INIT: begin
                // Requests are ignored while the sweep is running.
                wr_en = 1'b1;
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (lht_if.update_valid) begin
                    wr_en   = 1'b1;
                    wr_idx  = update_idx;
                    wr_data = update_hist;
                end
                if (lht_if.lookup_valid) begin
                    hist_valid_d = 1'b1;
                    // Same-index update this cycle: return the post-update value.
                    if (lht_if.update_valid && (update_idx == lookup_idx)) begin
                        hist_out_d = update_hist;
                    end else begin
                        hist_out_d = table_q[lookup_idx];
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_INIT;
            ptr_q        <= '0;
            hist_valid_q <= 1'b0;
            hist_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            hist_valid_q <= hist_valid_d;
            hist_out_q   <= hist_out_d;
        end
    end

    // Reset blocks the write so a request coinciding with reset is dropped.
    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            table_q[wr_idx] <= wr_data;
        end
    end

    assign lht_if.ready         = (state_q == ST_READY);
    assign lht_if.history_valid = hist_valid_q;
    assign lht_if.history_out   = hist_out_q;
endmodule

// File: tb/tb_local_history_table.sv
// ---------------------------------------------------------------------------
// tb_local_history_table
//   Scoreboard bench for local_history_table: a behavioural model decides
//   each lookup's expected history when the request is driven and queues it;
//   the queue is popped when the registered response appears.
// ---------------------------------------------------------------------------
module tb_local_history_table;
    localparam int ENTRIES = 64;
    localparam int HIST_W  = 10;
    localparam int PC_W    = 32;
    localparam int IDX_W   = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    local_history_table_if #(.PC_W(PC_W), .HIST_W(HIST_W)) bus ();

    local_history_table #(
        .ENTRIES (ENTRIES),
        .HIST_W  (HIST_W),
        .PC_W    (PC_W)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .lht_if (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [HIST_W-1:0] model_mem [ENTRIES];
    logic              model_ready = 1'b0;
    int                model_cnt   = 0;
    logic [HIST_W-1:0] model_hout  = '0;
    logic              model_hv    = 1'b0;
    logic [HIST_W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IDX_W-1:0] idx_of(input logic [PC_W-1:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    task automatic set_idle();
        bus.lookup_valid = 1'b0;
        bus.lookup_pc    = '0;
        bus.update_valid = 1'b0;
        bus.update_pc    = '0;
        bus.update_taken = 1'b0;
    endtask

    // Advance the model by one edge using the currently driven inputs, take
    // the edge, then compare ready / history_valid / history_out.
    task automatic cycle();
        logic [IDX_W-1:0]  li;
        logic [IDX_W-1:0]  ui;
        logic [HIST_W-1:0] upd;
        logic [HIST_W-1:0] exp_h;
        li       = idx_of(bus.lookup_pc);
        ui       = idx_of(bus.update_pc);
        model_hv = 1'b0;
        if (reset) begin
            model_ready = 1'b0;
            model_cnt   = 0;
            model_hout  = '0;
        end else if (!model_ready) begin
            model_mem[model_cnt] = '0;
            model_cnt++;
            if (model_cnt == ENTRIES) model_ready = 1'b1;
        end else begin
            upd = {model_mem[ui][HIST_W-2:0], bus.update_taken};
            if (bus.lookup_valid) begin
                model_hout = (bus.update_valid && (ui == li)) ? upd : model_mem[li];
                model_hv   = 1'b1;
                exp_q.push_back(model_hout);
            end
            if (bus.update_valid) model_mem[ui] = upd;
        end

        @(posedge clock);
        #1;
        check("ready", bus.ready, model_ready);
        check("history_valid", bus.history_valid, model_hv);
        if (exp_q.size() > 0) begin
            exp_h = exp_q.pop_front();
            check("history_out", bus.history_out, exp_h);
        end else begin
            check("history_out_hold", bus.history_out, model_hout);
        end
    endtask

    task automatic do_lookup(input logic [PC_W-1:0] pc);
        set_idle();
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = pc;
        cycle();
    endtask

    task automatic do_update(input logic [PC_W-1:0] pc, input logic taken);
        set_idle();
        bus.update_valid = 1'b1;
        bus.update_pc    = pc;
        bus.update_taken = taken;
        cycle();
    endtask

    task automatic drive_random_ops();
        bus.lookup_valid = 1'($urandom_range(0, 1));
        bus.lookup_pc    = $urandom();
        bus.update_valid = 1'($urandom_range(0, 1));
        bus.update_pc    = $urandom();
        bus.update_taken = 1'($urandom_range(0, 1));
    endtask

    // Count edges from reset release until ready; bounded.
    task automatic count_sweep(input string tag, input logic random_ops);
        int n;
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            if (random_ops) drive_random_ops();
            else set_idle();
            cycle();
            n = k;
            if (bus.ready) break;
        end
        check(tag, n, ENTRIES);
        set_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] pattern;
        set_idle();

        // Reset sweep
        reset = 1'b1;
        repeat (3) cycle();
        check("reset_history_out", bus.history_out, 0);
        reset = 1'b0;
        count_sweep("sweep_edges", 1'b0);
        for (int i = 0; i < ENTRIES; i++) begin
            do_lookup(PC_W'(i) << 2);
            check("sweep_zero", bus.history_out, 0);
        end

        // Shift and truncate on index 1
        pattern = 12'b101100000011;
        for (int k = 0; k < 12; k++) do_update(32'h0000_0104, pattern[11-k]);
        do_lookup(32'h0000_0104);
        check("shift_known", bus.history_out, 10'b1100000011);
        do_lookup(32'h0000_0008);
        check("index2_untouched", bus.history_out, 0);

        // Bypass on index 5
        do_update(32'h0000_0014, 1'b1);
        set_idle();
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = 32'h0000_0014;
        bus.update_valid = 1'b1;
        bus.update_pc    = 32'h0000_0014;
        bus.update_taken = 1'b1;
        cycle();
        check("bypass_known", bus.history_out, 10'h003);
        do_lookup(32'h0000_0014);
        check("bypass_after", bus.history_out, 10'h003);

        // Aliasing and independence
        do_update(32'h0000_0008, 1'b1);
        do_lookup(32'h0000_0108);
        check("alias_known", bus.history_out, 10'h001);
        set_idle();
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = 32'h0000_000C;
        bus.update_valid = 1'b1;
        bus.update_pc    = 32'h0000_0008;
        bus.update_taken = 1'b0;
        cycle();
        check("indep_known", bus.history_out, 10'h000);
        do_lookup(32'h0000_0008);
        check("indep_update_done", bus.history_out, 10'h002);

        // Streaming lookups with random interleaved updates
        for (int i = 0; i < ENTRIES; i++) begin
            bus.lookup_valid = 1'b1;
            bus.lookup_pc    = {$urandom_range(0, 1023), 6'(i), 2'b00} & 32'h0000_FFFC;
            bus.update_valid = 1'($urandom_range(0, 1));
            bus.update_pc    = ($urandom_range(0, 1) != 0) ? bus.lookup_pc : $urandom();
            bus.update_taken = 1'($urandom_range(0, 1));
            cycle();
        end
        set_idle();
        cycle();

        // Reset wins over a same-edge lookup/update, then mid-sweep reset
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = 32'h0000_0104;
        bus.update_valid = 1'b1;
        bus.update_pc    = 32'h0000_0104;
        bus.update_taken = 1'b1;
        reset = 1'b1;
        cycle();
        check("reset_wins_valid", bus.history_valid, 0);
        check("reset_wins_out", bus.history_out, 0);
        set_idle();
        repeat (2) cycle();
        reset = 1'b0;
        for (int k = 0; k < 19; k++) begin
            drive_random_ops();
            cycle();
        end
        set_idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        count_sweep("resweep_edges", 1'b1);
        for (int i = 0; i < ENTRIES; i++) begin
            do_lookup(PC_W'(i) << 2);
            check("resweep_zero", bus.history_out, 0);
        end
        set_idle();
        cycle();

        if (exp_q.size() != 0) check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/local_history_table.md
# local_history_table

Per-branch local history table for the tournament predictor. The table is indexed by the low PC bits and holds a HIST_W-bit taken/not-taken shift history for each entry. It sits directly upstream of the local prediction stage, whose 10-bit history input is driven by history_out. Resolved branches shift their outcome into the addressed entry. A post-reset sweep FSM clears the table one entry per cycle.

## Interface
- ENTRIES, 64: number of history entries; power of two, ≥2; IDX_W = log2(ENTRIES)
- HIST_W, 10: history bits per entry; must equal the downstream prediction index width
- PC_W, 32: PC width; requires PC_W ≥ IDX_W+2
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; restarts the clear sweep
- lookup_valid  in  1  lookup request this cycle
- lookup_pc  in  PC_W  branch PC to look up
- update_valid  in  1  resolved branch outcome this cycle
- update_pc  in  PC_W  PC of the resolved branch
- update_taken  in  1  resolved direction (1 = taken)
- ready  out  1  table initialised; lookups and updates accepted
- history_valid  out  1  history_out carries a lookup result
- history_out  out  HIST_W  history of the looked-up entry

## Operation
- Index = pc[IDX_W+1:2], with word-aligned PCs. The upper PC bits are ignored, so aliasing entries share history by design.
- FSM states:
  - INIT: entry[ptr] <= 0; ptr <= ptr+1; ready = 0.
  - INIT → READY on the cycle that clears ptr == ENTRIES-1.
  - READY: normal operation. It is the only state with ready = 1.
- reset in any state, including mid-sweep: state <= INIT, ptr <= 0, history_valid <= 0, history_out <= 0. The sweep then restarts from entry 0.
- Reset values: ready 0, history_valid 0, history_out 0. Table contents are undefined until the sweep covers them.
- Update (READY, update_valid): entry[u] <= {entry[u][HIST_W-2:0], update_taken}.
  - The shift is left and the newest outcome lands in the LSB.
  - The MSB is dropped with no saturation.
- Lookup (READY, lookup_valid): history_out <= entry[l]; history_valid <= 1.
- No lookup (or not READY): history_valid <= 0. history_out holds its last value.
- Bypass: a lookup and an update to the same index in the same cycle return the post-update value, i.e. {entry[l][HIST_W-2:0], update_taken}.
- A lookup and an update to different indices in the same cycle are independent. Both complete.
- In INIT, lookup_valid and update_valid are ignored: no table write and no history_valid.

## Timing
- Lookup latency is 1 cycle. A request sampled at edge N gives history_out/history_valid valid after edge N and held through edge N+1. Back-to-back lookups sustain 1 per cycle.
- An update written at edge N is visible to a lookup sampled at edge N+1 or later. Same-edge visibility comes only through the bypass.
- Initialisation after reset deasserts:
  - Edges 1..ENTRIES clear entries 0..ENTRIES-1.
  - ready goes high after edge ENTRIES (after 64 edges at default).
  - The first lookup is accepted at edge ENTRIES+1.
- A reset asserted on the same edge as a lookup or update wins. Neither is performed.
- ready is a registered output and has no combinational path from the inputs.

## Test plan
- Reset sweep: assert reset 3 cycles, then deassert → ready = 0 for 64 edges and 1 after edge 64. A lookup of every index 0..63 then returns history_out = 10'h000.
- Shift and truncate: 12 updates to pc 0x0000_0104 (index 1) with taken = 1,0,1,1,0,0,0,0,0,0,1,1 → a lookup of 0x104 returns 10'b1100000011. Index 2 still reads 10'h000.
- Bypass: entry 5 = 10'h001. Same cycle: lookup pc 0x14 and update pc 0x14 with taken = 1 → history_out = 10'h003 next cycle. A separate lookup of 0x14 in the cycle after that also reads 10'h003.
- Aliasing and independence: update pc 0x0000_0008 taken = 1, then a lookup of pc 0x0000_0108 (same index 2) → 10'h001. A same-cycle lookup of index 3 during an update of index 2 → the index 3 value is unchanged.
- Mid-sweep reset: reset at edge 20 of INIT → ptr restarts. ready rises exactly 64 edges after the second deassertion. Lookup and update inputs driven during INIT produce history_valid = 0 and no writes (all entries read 0).
- Streaming: 64 consecutive lookups of indices 0..63 with random interleaved updates → history_valid is high every cycle, and each value matches a reference model including the bypass.
